mux2_share_arbiter: RTL and testbench
=====================================

// Module: mux2_share_arbiter
//
// PURPOSE
//   Shares one 2:1 mux datapath (and the resource downstream of it) between
//   two requesters. Grants use round-robin priority and include a bounded
//   hold, so neither requester can starve the other.
//   Drives the mux select and one-hot grants; sits between requester control
//   logic and the Mux2 select input.
//
// PARAMETERS
//   MAX_HOLD  4  max consecutive granted cycles while the other side waits (>=2)
//
// PORTS
//   clk       in   1              clock, rising edge
//   rst       in   1              reset, asynchronous, active-high
//   req0      in   1              requester 0 wants the datapath
//   req1      in   1              requester 1 wants the datapath
//   done0     in   1              requester 0 releases (valid only while gnt0)
//   done1     in   1              requester 1 releases (valid only while gnt1)
//   gnt0      out  1              requester 0 owns datapath this cycle
//   gnt1      out  1              requester 1 owns datapath this cycle
//   sel       out  1              mux select: 0 = in0 path, 1 = in1 path
//   busy      out  1              gnt0 | gnt1
//   hold_cnt  out  $clog2(MAX_HOLD) cycles current owner has held, minus 1
//
// BEHAVIOUR
//   - All outputs are registered. gnt0 and gnt1 are never both 1.
//   - States: IDLE, G0, G1. A 1-bit pointer `last` records the most recent
//     owner.
//   - Reset (async, any time, including mid-grant):
//       state = IDLE, last = 1, gnt0 = gnt1 = 0, sel = 0, busy = 0,
//       hold_cnt = 0.
//   - IDLE:
//       req0 & req1 -> G(!last)
//       req0 only   -> G0
//       req1 only   -> G1
//       none        -> stay IDLE
//     A grant appears on the edge after the request: latency is 1 cycle.
//   - On entry to Gk: last <= k, sel <= k, hold_cnt <= 0.
//   - In Gk, evaluated each edge:
//       release = done_k | !req_k
//       preempt = req_other & (hold_cnt == MAX_HOLD-1)
//       release | preempt -> G(other) if req_other, else IDLE
//       otherwise         -> stay Gk, hold_cnt++ (saturates at MAX_HOLD-1)
//   - A handoff Gk -> G(other) happens on one edge: no idle bubble, and
//     never a cycle with both grants asserted.
//   - A lone requester with no competitor holds indefinitely; hold_cnt
//     saturates.
//   - sel holds its last value while IDLE, so the mux output does not
//     glitch between grants.
//   - done_k without gnt_k is ignored. Simultaneous done_k and req_other
//     -> G(other) next cycle.
//
// TESTING
//   1. Reset: assert rst mid-cycle while in G1
//        -> gnt0 = gnt1 = busy = 0, sel = 0, hold_cnt = 0 immediately
//           (no clock edge needed).
//   2. Single request: req0 = 1 at cycle 0
//        -> gnt0 = 1, sel = 0 at cycle 1
//      done0 = 1 at cycle 3
//        -> IDLE at cycle 4, sel stays 0.
//   3. Tie after reset: req0 = req1 = 1
//        -> G0 first (last = 1)
//      done0
//        -> G1 on the next edge with no bubble, gnt0 and gnt1 never both 1.
//   4. Preemption (MAX_HOLD = 4): req0 held, req1 asserted from cycle 1
//        -> gnt0 for 4 cycles (hold_cnt 0..3), then gnt1 = 1, sel = 1.
//   5. Saturation: req1 alone for 10 cycles
//        -> gnt1 stays 1, hold_cnt saturates at 3.
//      Spurious done0
//        -> no effect.
//   6. Alternation: req0 = req1 = 1 for 20 cycles with done pulsed every
//      2 cycles
//        -> grants alternate 0, 1, 0, 1.
//      Each check also requires busy == gnt0 | gnt1.

Source files
------------

// File: rtl/mux2_share_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux datapath.
// The hold limit bounds how long one requester can keep the mux while the other waits.
module mux2_share_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req0,
    input  logic                        req1,
    input  logic                        done0,
    input  logic                        done1,
    output logic                        gnt0,
    output logic                        gnt1,
    output logic                        sel,
    output logic                        busy,
    output logic [$clog2(MAX_HOLD)-1:0] hold_cnt
);

    localparam int unsigned          HOLD_W   = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0]    HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                last;
    logic                last_nx;
    logic                sel_nx;
    logic [HOLD_W-1:0]   hold_nx;
    logic                grant_any;
    logic                grant_to;
    logic                own;
    logic                req_own;
    logic                req_oth;
    logic                done_own;

    // State, pointer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            sel      <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            last     <= last_nx;
            gnt0     <= (state_nx == G0);
            gnt1     <= (state_nx == G1);
            sel      <= sel_nx;
            busy     <= (state_nx != IDLE);
            hold_cnt <= hold_nx;
        end
    end

    // Next-state: round-robin on ties, release or hold-limit preemption while granted
    always_comb begin
        state_nx  = state;
        last_nx   = last;
        sel_nx    = sel;
        hold_nx   = hold_cnt;
        grant_any = 1'b0;
        grant_to  = 1'b0;
        own       = (state == G1);
        req_own   = own ? req1 : req0;
        req_oth   = own ? req0 : req1;
        done_own  = own ? done1 : done0;

        unique case (state)
            IDLE: begin
                hold_nx = '0;
                if (req0 && req1) begin
                    grant_any = 1'b1;
                    grant_to  = ~last;
                end else if (req0) begin
                    grant_any = 1'b1;
                    grant_to  = 1'b0;
                end else if (req1) begin
                    grant_any = 1'b1;
                    grant_to  = 1'b1;
                end
            end
            G0, G1: begin
                if (done_own || !req_own || (req_oth && (hold_cnt == HOLD_MAX))) begin
                    if (req_oth) begin
                        grant_any = 1'b1;
                        grant_to  = ~own;
                    end else begin
                        state_nx = IDLE;
                        hold_nx  = '0;
                    end
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_nx = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                hold_nx  = '0;
            end
        endcase

        // Entering a grant state (from IDLE or as a same-edge handoff)
        if (grant_any) begin
            state_nx = grant_to ? G1 : G0;
            last_nx  = grant_to;
            sel_nx   = grant_to;
            hold_nx  = '0;
        end
    end

endmodule

// File: tb/tb_mux2_share_arbiter.sv
// Directed bench for mux2_share_arbiter: vector table plus async-reset and alternation sequences.
module tb_mux2_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, done0, done1;
    logic       gnt0, gnt1, sel, busy;
    logic [1:0] hold_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       r, q0, q1, d0, d1;
        logic       g0, g1, s, b;
        logic [1:0] h;
    } vec_t;

    vec_t vecs[$];

    mux2_share_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .done0(done0), .done1(done1), .gnt0(gnt0), .gnt1(gnt1),
        .sel(sel), .busy(busy), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, q0, q1, d0, d1, g0, g1, s, b, input logic [1:0] h);
        vec_t v;
        v.r = r; v.q0 = q0; v.q1 = q1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.s = s; v.b = b; v.h = h;
        vecs.push_back(v);
    endtask

    task automatic chk1(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check(input string tag, input logic g0, g1, s, b, input logic [1:0] h);
        chk1({tag, ".gnt0"}, {1'b0, gnt0}, {1'b0, g0});
        chk1({tag, ".gnt1"}, {1'b0, gnt1}, {1'b0, g1});
        chk1({tag, ".sel"}, {1'b0, sel}, {1'b0, s});
        chk1({tag, ".busy"}, {1'b0, busy}, {1'b0, b});
        chk1({tag, ".hold_cnt"}, hold_cnt, h);
        chk1({tag, ".busy_or"}, {1'b0, busy}, {1'b0, gnt0 | gnt1});
        chk1({tag, ".onehot"}, {1'b0, gnt0 & gnt1}, 2'd0);
    endtask

    task automatic drive(input logic r, q0, q1, d0, d1);
        @(negedge clk);
        rst = r; req0 = q0; req1 = q1; done0 = d0; done1 = d1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; done0 = 1'b0; done1 = 1'b0;

        //   r  q0 q1 d0 d1   g0 g1 s  b  h
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // reset state
        add(0, 1, 0, 0, 0,   1, 0, 0, 1, 0);  // single request, 1-cycle latency
        add(0, 1, 0, 0, 0,   1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0,   1, 0, 0, 1, 2);
        add(0, 1, 0, 1, 0,   0, 0, 0, 0, 0);  // done0 -> IDLE, sel stays 0
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0,   0, 1, 1, 1, 0);  // tie with last=0 -> G1
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // reset from G1
        add(0, 1, 1, 0, 0,   1, 0, 0, 1, 0);  // tie after reset -> G0
        add(0, 1, 1, 1, 0,   0, 1, 1, 1, 0);  // done0 with req1 -> G1, no bubble
        add(0, 1, 1, 0, 0,   0, 1, 1, 1, 1);
        add(0, 0, 1, 0, 1,   0, 0, 1, 0, 0);  // done1, nobody waiting -> IDLE, sel holds 1
        add(0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0,   1, 0, 0, 1, 0);  // preemption sequence
        add(0, 1, 1, 0, 0,   1, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0,   1, 0, 0, 1, 2);
        add(0, 1, 1, 0, 0,   1, 0, 0, 1, 3);
        add(0, 1, 1, 0, 0,   0, 1, 1, 1, 0);  // hold limit reached -> G1
        add(0, 1, 1, 0, 0,   0, 1, 1, 1, 1);
        add(0, 0, 1, 0, 0,   0, 1, 1, 1, 2);
        add(0, 0, 1, 0, 0,   0, 1, 1, 1, 3);
        add(0, 0, 1, 1, 0,   0, 1, 1, 1, 3);  // spurious done0 ignored, saturated
        add(0, 0, 1, 0, 0,   0, 1, 1, 1, 3);
        add(0, 0, 0, 0, 0,   0, 0, 1, 0, 0);  // !req1 releases
        add(0, 0, 0, 1, 1,   0, 0, 1, 0, 0);  // done while IDLE ignored

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].q0, vecs[i].q1, vecs[i].d0, vecs[i].d1);
            check($sformatf("vec%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].s, vecs[i].b, vecs[i].h);
        end

        // Saturation: lone req1 for 10 cycles, spurious done0 midway
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, (i == 5), 0);
            check($sformatf("sat%0d", i), 0, 1, 1, 1, (i > 3) ? 2'd3 : 2'(i));
        end

        // Async reset mid-cycle while in G1, no edge needed
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("rst_held", 0, 0, 0, 0, 0);

        // Alternation: both requesting, done pulsed every 2 cycles
        for (int i = 0; i < 20; i++) begin
            logic owner;
            logic [1:0] h;
            owner = (((i + 1) / 2) % 2) == 1;
            h = (i == 0 || (i % 2) == 1) ? 2'd0 : 2'd1;
            drive(0, 1, 1, (i % 2) == 1, (i % 2) == 1);
            check($sformatf("alt%0d", i), ~owner, owner, owner, 1, h);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
